// File: rtl/brew_timer_if.sv
// ============================================================================
// Module      : brew_timer_if
// Description : Control/status bundle between the brew FSM and brew_timer.
//               BCD digits exist only when BREW_TIMER_BCD_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface brew_timer_if #(
  parameter int DUR_W = 8
);
  logic             start;
  logic             cancel;
  logic [DUR_W-1:0] dur;
  logic [3:0]       speed;
  logic             t_expired;
  logic             busy;
  logic [DUR_W-1:0] remaining;
`ifdef BREW_TIMER_BCD_EN
  logic [3:0]       rem_tens;
  logic [3:0]       rem_units;
`endif

  modport master (
    output start, cancel, dur, speed,
    input  t_expired, busy, remaining
`ifdef BREW_TIMER_BCD_EN
    , input rem_tens, rem_units
`endif
  );

  modport slave (
    input  start, cancel, dur, speed,
    output t_expired, busy, remaining
`ifdef BREW_TIMER_BCD_EN
    , output rem_tens, rem_units
`endif
  );
endinterface

`default_nettype wire

// File: rtl/brew_timer.sv
// ============================================================================
// Module      : brew_timer
// Description : Speed-scaled brew countdown with single-cycle expiry pulse.
//               Optional BCD digit outputs via BREW_TIMER_BCD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module brew_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int DUR_W    = 8
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  brew_timer_if.slave  bus
);

  localparam int c_acc_w = $clog2(TICK_DIV + 16);
  localparam logic [c_acc_w-1:0] c_tick = c_acc_w'(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_acc_w-1:0] r_acc, w_acc_next, w_sum;
  logic [DUR_W-1:0]   r_rem, w_rem_next;
  logic               r_busy, w_busy_next;
  logic               r_expired, w_expired_next;

  assign w_sum = r_acc + c_acc_w'(bus.speed);

  always_comb begin
    w_state_next   = r_state;
    w_acc_next     = r_acc;
    w_rem_next     = r_rem;
    w_expired_next = 1'b0;

    if (bus.cancel && (r_state == S_RUN)) begin
      w_state_next = S_IDLE;
      w_acc_next   = '0;
      w_rem_next   = '0;
    end else if (bus.start && !bus.cancel) begin
      // Zero duration enters DONE with the pulse still pending; DONE emits it next cycle.
      w_rem_next   = bus.dur;
      w_acc_next   = '0;
      w_state_next = (bus.dur != '0) ? S_RUN : S_DONE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_sum >= c_tick) begin
            w_acc_next = w_sum - c_tick;
            w_rem_next = r_rem - DUR_W'(1);
            if (r_rem == DUR_W'(1)) begin
              w_state_next   = S_DONE;
              w_expired_next = 1'b1;
            end
          end else begin
            w_acc_next = w_sum;
          end
        end
        S_DONE: begin
          if (!r_expired) begin
            w_expired_next = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_IDLE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end

    w_busy_next = (w_state_next == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_rem     <= '0;
      r_busy    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_acc     <= w_acc_next;
      r_rem     <= w_rem_next;
      r_busy    <= w_busy_next;
      r_expired <= w_expired_next;
    end
  end

  assign bus.t_expired = r_expired;
  assign bus.busy      = r_busy;
  assign bus.remaining = r_rem;

`ifdef BREW_TIMER_BCD_EN
  logic [31:0] w_rem_ext;
  logic [3:0]  w_tens, w_units;
  logic [3:0]  r_tens, r_units;

  // Digits follow the next-state count so they change on the same edge as remaining.
  assign w_rem_ext = 32'(w_rem_next);
  assign w_tens    = 4'((w_rem_ext % 32'd100) / 32'd10);
  assign w_units   = 4'(w_rem_ext % 32'd10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else begin
      r_tens  <= w_tens;
      r_units <= w_units;
    end
  end

  assign bus.rem_tens  = r_tens;
  assign bus.rem_units = r_units;
`endif

endmodule

`default_nettype wire

// File: tb/tb_brew_timer.sv
// ============================================================================
// Module      : tb_brew_timer
// Description : Directed self-checking bench for brew_timer at TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brew_timer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   n_pulse;
  int   p0;

  brew_timer_if #(.DUR_W(8)) bus ();

  brew_timer #(
    .TICK_DIV (4),
    .DUR_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.t_expired) n_pulse++;
    end
  endtask

  task automatic go(input logic [7:0] d);
    bus.dur   = d;
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [7:0] prev;
    logic       mono;
    n_cmp = 0; n_err = 0; n_pulse = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.dur = 8'd0; bus.speed = 4'd1;
    tick(2);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rem", 32'(bus.remaining), 0);
    check("rst_exp", 32'(bus.t_expired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Basic countdown, speed 1
    bus.speed = 4'd1;
    p0 = n_pulse;
    go(8'd3);
    check("basic_busy0", 32'(bus.busy), 1);
    check("basic_rem0", 32'(bus.remaining), 3);
    tick(3);
    check("basic_rem_e3", 32'(bus.remaining), 3);
    tick(1);
    check("basic_rem_e4", 32'(bus.remaining), 2);
    tick(4);
    check("basic_rem_e8", 32'(bus.remaining), 1);
    tick(4);
    check("basic_rem_e12", 32'(bus.remaining), 0);
    check("basic_busy_e12", 32'(bus.busy), 0);
    check("basic_exp_e12", 32'(bus.t_expired), 1);
    tick(1);
    check("basic_exp_e13", 32'(bus.t_expired), 0);
    check("basic_pulses", 32'(n_pulse - p0), 1);

    // Fractional rate, speed 3
    bus.speed = 4'd3;
    go(8'd3);
    tick(1);
    check("frac_rem_e1", 32'(bus.remaining), 3);
    tick(1);
    check("frac_rem_e2", 32'(bus.remaining), 2);
    tick(1);
    check("frac_rem_e3", 32'(bus.remaining), 1);
    tick(1);
    check("frac_exp_e4", 32'(bus.t_expired), 1);
    tick(1);
    check("frac_exp_e5", 32'(bus.t_expired), 0);

    // Freeze with speed 0, resume from held acc, then cancel on a tick edge
    bus.speed = 4'd1;
    go(8'd2);
    tick(2);
    bus.speed = 4'd0;
    tick(20);
    check("frz_rem", 32'(bus.remaining), 2);
    check("frz_busy", 32'(bus.busy), 1);
    bus.speed = 4'd1;
    tick(1);
    check("res_rem_a", 32'(bus.remaining), 2);
    tick(1);
    check("res_rem_b", 32'(bus.remaining), 1);
    tick(3);
    p0 = n_pulse;
    bus.cancel = 1'b1;
    tick(1);
    bus.cancel = 1'b0;
    check("cxl_rem", 32'(bus.remaining), 0);
    check("cxl_busy", 32'(bus.busy), 0);
    tick(3);
    check("cxl_pulses", 32'(n_pulse - p0), 0);

    // Zero duration
    go(8'd0);
    check("zero_exp_e0", 32'(bus.t_expired), 0);
    check("zero_busy_e0", 32'(bus.busy), 0);
    tick(1);
    check("zero_exp_e1", 32'(bus.t_expired), 1);
    tick(1);
    check("zero_exp_e2", 32'(bus.t_expired), 0);

    // dur 255 at speed 15: monotonic count, exactly one pulse
    bus.speed = 4'd15;
    p0 = n_pulse;
    go(8'd255);
    prev = bus.remaining;
    mono = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (!bus.busy) break;
      tick(1);
      if (bus.remaining > prev) mono = 1'b0;
      prev = bus.remaining;
    end
    check("big_done", 32'(bus.busy), 0);
    check("big_mono", 32'(mono), 1);
    tick(3);
    check("big_rem", 32'(bus.remaining), 0);
    check("big_pulses", 32'(n_pulse - p0), 1);

    // Restart while running with remaining=1
    bus.speed = 4'd1;
    go(8'd2);
    tick(4);
    check("rst_pre", 32'(bus.remaining), 1);
    p0 = n_pulse;
    go(8'd5);
    check("rs_rem", 32'(bus.remaining), 5);
    check("rs_busy", 32'(bus.busy), 1);
    tick(3);
    check("rs_acc_clr", 32'(bus.remaining), 5);
    tick(1);
    check("rs_tick", 32'(bus.remaining), 4);
    tick(18);
    check("rs_pulses", 32'(n_pulse - p0), 1);
    check("rs_idle", 32'(bus.busy), 0);

    // start + cancel together in IDLE
    p0 = n_pulse;
    bus.cancel = 1'b1;
    go(8'd7);
    bus.cancel = 1'b0;
    check("sc_busy", 32'(bus.busy), 0);
    check("sc_rem", 32'(bus.remaining), 0);
    tick(2);
    check("sc_pulses", 32'(n_pulse - p0), 0);

    // Asynchronous reset mid-run
    go(8'd9);
    tick(6);
    check("ar_pre_busy", 32'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_busy", 32'(bus.busy), 0);
    check("ar_rem", 32'(bus.remaining), 0);
    check("ar_exp", 32'(bus.t_expired), 0);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pulse;
    tick(40);
    check("ar_pulses", 32'(n_pulse - p0), 0);
    check("ar_idle", 32'(bus.busy), 0);

`ifdef BREW_TIMER_BCD_EN
    bus.speed = 4'd1;
    go(8'd47);
    check("bcd_tens0", 32'(bus.rem_tens), 4);
    check("bcd_units0", 32'(bus.rem_units), 7);
    tick(4);
    check("bcd_tens1", 32'(bus.rem_tens), 4);
    check("bcd_units1", 32'(bus.rem_units), 6);
    bus.cancel = 1'b1;
    tick(1);
    bus.cancel = 1'b0;
    check("bcd_clr", 32'(bus.rem_units), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
